// File: rtl/set_sched_pkg.sv
// Shared types and widths for the SET job scheduler.
package set_sched_pkg;

  // Scheduler FSM encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_e;

  localparam int CENTRAL_W       = 16;  // {x1,y1,x2,y2} nibbles
  localparam int RADIUS_W        = 8;   // {r1,r2} nibbles
  localparam int CAND_W          = 8;   // SET candidate count
  localparam int CNT_W           = 8;   // watchdog counter width
  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first active request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   grant_idx_o
);

  // Scan NUM_REQ positions starting at ptr and latch onto the first hit.
  always_comb begin : scan
    int  idx;
    logic found;
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_i) + k) % NUM_REQ;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = PTR_W'(idx);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/set_job_arbiter.sv
// Round-robin scheduler sharing one SET intersection engine among NUM_REQ
// requesters. One job in flight; a watchdog aborts jobs on a hung engine.
module set_job_arbiter
  import set_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [CENTRAL_W*NUM_REQ-1:0] req_central,
  input  logic [RADIUS_W*NUM_REQ-1:0]  req_radius,
  output logic [NUM_REQ-1:0]           ack,
  output logic [NUM_REQ-1:0]           done,
  output logic [CAND_W-1:0]            result,
  output logic                         err,
  output logic                         set_en,
  output logic [CENTRAL_W-1:0]         set_central,
  output logic [RADIUS_W-1:0]          set_radius,
  input  logic                         set_busy,
  input  logic                         set_valid,
  input  logic [CAND_W-1:0]            set_candidate
);

  localparam int                 PTR_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // The watchdog fires on the TIMEOUT-th WAIT cycle without valid; the
  // counter reads 0 on the first WAIT cycle.
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0     = NUM_REQ'(1);
  localparam logic [PTR_W-1:0]   LAST_IDX     = PTR_W'(NUM_REQ - 1);

  sched_state_e         state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [CENTRAL_W-1:0] central_q, central_d;
  logic [RADIUS_W-1:0]  radius_q, radius_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [CAND_W-1:0]    result_q, result_d;
  logic                 err_q, err_d;
  logic                 set_en_q, set_en_d;

  logic [NUM_REQ-1:0]   grant_oh_s;
  logic [PTR_W-1:0]     grant_idx_s;
  logic [CENTRAL_W-1:0] grant_central_s;
  logic [RADIUS_W-1:0]  grant_radius_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req_i       (req),
    .ptr_i       (ptr_q),
    .grant_o     (grant_oh_s),
    .grant_idx_o (grant_idx_s)
  );

  // Mux the granted requester's job fields; grant is one-hot or all zero.
  always_comb begin
    grant_central_s = '0;
    grant_radius_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_central_s = grant_central_s |
        ({CENTRAL_W{grant_oh_s[i]}} & req_central[i*CENTRAL_W +: CENTRAL_W]);
      grant_radius_s  = grant_radius_s |
        ({RADIUS_W{grant_oh_s[i]}} & req_radius[i*RADIUS_W +: RADIUS_W]);
    end
  end

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    central_d = central_q;
    radius_d  = radius_q;
    cnt_d     = cnt_q;
    ack_d     = '0;
    done_d    = '0;
    result_d  = '0;
    err_d     = 1'b0;
    set_en_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if ((req != '0) && !set_busy) begin
          // ack and set_en both become visible in the ISSUE cycle, with the
          // job fields already registered on set_central/set_radius.
          owner_d   = grant_idx_s;
          central_d = grant_central_s;
          radius_d  = grant_radius_s;
          ack_d     = grant_oh_s;
          set_en_d  = 1'b1;
          state_d   = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (set_valid) begin
          // Valid wins over a coinciding watchdog expiry.
          result_d = set_candidate;
          err_d    = 1'b0;
          done_d   = ONE_HOT0 << owner_q;
          state_d  = RESP;
        end else if (cnt_q == TIMEOUT_LAST) begin
          result_d = '0;
          err_d    = 1'b1;
          done_d   = ONE_HOT0 << owner_q;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (owner_q == LAST_IDX) begin
          ptr_d = '0;
        end else begin
          ptr_d = owner_q + PTR_W'(1);
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any job in flight without a done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      central_q <= '0;
      radius_q  <= '0;
      cnt_q     <= '0;
      ack_q     <= '0;
      done_q    <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
      set_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      central_q <= central_d;
      radius_q  <= radius_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      result_q  <= result_d;
      err_q     <= err_d;
      set_en_q  <= set_en_d;
    end
  end

  assign ack         = ack_q;
  assign done        = done_q;
  assign result      = result_q;
  assign err         = err_q;
  assign set_en      = set_en_q;
  assign set_central = central_q;
  assign set_radius  = radius_q;

endmodule
